// File: rtl/npc_pkg.sv
// Shared NPC core definitions: ifu state encoding, reset/default constants and
// the read-response code. Also imported by the core top and load/store unit.
package npc_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IFU_BOOT,
    IFU_REQ,
    IFU_WAIT,
    IFU_HOLD,
    IFU_NEXT
  } ifu_state_e;

  // Instruction fetches must be word aligned.
  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bundle: memory read port (ar/r channels), decode handshake and
// next-PC return path.
//   master : the fetch unit (drives requests, instruction to decode)
//   slave  : memory + decode/back end
interface ifu_if;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fault;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output arvalid, araddr, rready, inst_valid, inst, pc, fault,
    input  arready, rvalid, rdata, rresp, inst_ready, npc_valid, npc
  );

  modport slave (
    input  arvalid, araddr, rready, inst_valid, inst, pc, fault,
    output arready, rvalid, rdata, rresp, inst_ready, npc_valid, npc
  );
endinterface

// File: rtl/ifu.sv
// Multi-cycle instruction fetch unit.
// Holds the architectural PC, issues one read per instruction, captures the
// returned word and hands {inst, pc, fault} to decode, then waits for the
// back end to return the next PC before fetching again.
// Ports:
//   clk  - core clock, all state changes on posedge
//   rst  - asynchronous active-high reset
//   bus  - ifu_if.master: ar/r read port, inst_* decode handshake, npc return
module ifu
  import npc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  ifu_if.master  bus
);

  ifu_state_e  state;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        fault_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        inst_valid_r;

  assign bus.arvalid    = arvalid_r;
  assign bus.araddr     = pc_r;
  assign bus.rready     = rready_r;
  assign bus.inst_valid = inst_valid_r;
  assign bus.inst       = inst_r;
  assign bus.pc         = pc_r;
  assign bus.fault      = fault_r;

  // Handshake outputs are registered alongside the state so they never
  // depend combinationally on inputs. arvalid is only raised when the PC
  // being entered into REQ is aligned; a misaligned REQ issues nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IFU_BOOT;
      pc_r         <= RESET_PC;
      inst_r       <= NOP_INST;
      fault_r      <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      case (state)
        IFU_BOOT: begin
          state     <= IFU_REQ;
          arvalid_r <= word_aligned(pc_r);
        end
        IFU_REQ: begin
          if (!word_aligned(pc_r)) begin
            inst_r       <= NOP_INST;
            fault_r      <= 1'b1;
            inst_valid_r <= 1'b1;
            state        <= IFU_HOLD;
          end else if (bus.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state     <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (bus.rvalid) begin
            if (bus.rresp == RESP_OKAY) begin
              inst_r  <= bus.rdata;
              fault_r <= 1'b0;
            end else begin
              inst_r  <= NOP_INST;
              fault_r <= 1'b1;
            end
            rready_r     <= 1'b0;
            inst_valid_r <= 1'b1;
            state        <= IFU_HOLD;
          end
        end
        IFU_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_r <= 1'b0;
            // Same-cycle next PC skips NEXT for a 3-cycle fetch loop.
            if (bus.npc_valid) begin
              pc_r      <= bus.npc;
              arvalid_r <= word_aligned(bus.npc);
              state     <= IFU_REQ;
            end else begin
              state <= IFU_NEXT;
            end
          end
        end
        IFU_NEXT: begin
          if (bus.npc_valid) begin
            pc_r      <= bus.npc;
            arvalid_r <= word_aligned(bus.npc);
            state     <= IFU_REQ;
          end
        end
        default: begin
          state        <= IFU_BOOT;
          arvalid_r    <= 1'b0;
          rready_r     <= 1'b0;
          inst_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Scoreboarded bench for ifu: a memory responder with programmable wait
// states, directed next-PC stimulus, and a monitor comparing every HOLD cycle
// against the queued expected {inst, pc, fault}.
module tb_ifu;
  import npc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ifu_if bus ();
  ifu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  // memory responder config/state
  int          ar_dly   = 0;
  int          r_dly    = 0;
  logic [1:0]  resp_cfg = 2'b00;
  bit          mem_en   = 1'b1;
  int          m_st     = 0;
  int          m_cnt    = 0;
  logic [31:0] m_addr   = '0;

  // monitor state
  exp_t cur;
  bit   prev_iv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p, input logic f);
    exp_t e;
    e.inst  = i;
    e.pc    = p;
    e.fault = f;
    return e;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0093;
      32'h8000_0004: return 32'h0030_0193;
      32'h8000_0010: return 32'h0020_0113;
      default:       return 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  // Memory model: reacts at negedge to the stable DUT outputs.
  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (!mem_en) begin
        m_st  = 0;
        m_cnt = 0;
      end else begin
        case (m_st)
          0: begin
            bus.rvalid = 1'b0;
            if (bus.arvalid) begin
              if (m_cnt < ar_dly) begin
                bus.arready = 1'b0;
                m_cnt++;
              end else begin
                bus.arready = 1'b1;
                m_addr      = bus.araddr;
                m_cnt       = 0;
                m_st        = 1;
              end
            end else begin
              bus.arready = 1'b0;
            end
          end
          1: begin
            bus.arready = 1'b0;
            if (m_cnt < r_dly) begin
              bus.rvalid = 1'b0;
              m_cnt++;
            end else begin
              bus.rvalid = 1'b1;
              bus.rdata  = mem_word(m_addr);
              bus.rresp  = resp_cfg;
              m_cnt      = 0;
              m_st       = 2;
            end
          end
          default: begin
            bus.rvalid = 1'b0;
            m_st       = 0;
          end
        endcase
      end
    end
  end

  // Monitor: pop on inst_valid rise, compare every cycle it stays high.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.inst_valid) begin
        if (!prev_iv) begin
          if (sb.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_inst: got inst %h pc %h, expected none", bus.inst, bus.pc);
          end else begin
            cur = sb.pop_front();
          end
        end
        check("mon inst",  bus.inst,          cur.inst);
        check("mon pc",    bus.pc,            cur.pc);
        check("mon fault", 32'(bus.fault),    32'(cur.fault));
      end
      prev_iv = bus.inst_valid;
    end
  end

  // Count negedges until inst_valid; record first arvalid and check araddr.
  task automatic run_fetch(input string name, input logic [31:0] exp_addr,
                           input int exp_ar, input int exp_iv);
    int n_ar;
    int n_iv;
    n_ar = -1;
    n_iv = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.inst_ready = 1'b0;
      bus.npc_valid  = 1'b0;
      if (bus.arvalid) begin
        if (n_ar < 0) n_ar = k;
        check({name, " araddr"}, bus.araddr, exp_addr);
      end
      if (bus.inst_valid) begin
        n_iv = k;
        break;
      end
    end
    check({name, " arvalid_cycle"}, n_ar, exp_ar);
    check({name, " inst_valid_cycle"}, n_iv, exp_iv);
  endtask

  task automatic issue_npc(input logic [31:0] a);
    bus.inst_ready = 1'b1;
    bus.npc_valid  = 1'b1;
    bus.npc        = a;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " arvalid"},    32'(bus.arvalid),    32'd0);
    check({name, " rready"},     32'(bus.rready),     32'd0);
    check({name, " inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check({name, " inst"},       bus.inst,            NOP_INST);
    check({name, " pc"},         bus.pc,              RESET_PC);
    check({name, " fault"},      32'(bus.fault),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    bus.npc        = '0;

    // reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");

    // zero-wait boot fetch: BOOT, REQ, WAIT, then HOLD
    sb.push_back(mk(32'h0010_0093, RESET_PC, 1'b0));
    rst = 1'b0;
    run_fetch("boot", RESET_PC, 1, 3);

    // decode stalls 4 cycles; monitor verifies stability
    repeat (4) @(negedge clk);

    // same-cycle consume+npc, then 3 arready-low and 2 rvalid-low cycles
    ar_dly = 3;
    r_dly  = 2;
    sb.push_back(mk(32'h0020_0113, 32'h8000_0010, 1'b0));
    issue_npc(32'h8000_0010);
    run_fetch("stall", 32'h8000_0010, 1, 8);
    ar_dly = 0;
    r_dly  = 0;

    // consume without npc: NEXT, nothing issued while waiting
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("next arvalid",    32'(bus.arvalid),    32'd0);
      check("next inst_valid", 32'(bus.inst_valid), 32'd0);
      @(negedge clk);
    end

    // error response
    resp_cfg = 2'b10;
    sb.push_back(mk(NOP_INST, 32'h8000_0004, 1'b1));
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0004;
    run_fetch("err", 32'h8000_0004, 1, 3);
    resp_cfg = 2'b00;

    // normal refetch clears fault
    sb.push_back(mk(32'h0030_0193, 32'h8000_0004, 1'b0));
    issue_npc(32'h8000_0004);
    run_fetch("refetch", 32'h8000_0004, 1, 3);

    // misaligned: no request, HOLD next cycle
    sb.push_back(mk(NOP_INST, 32'h8000_0002, 1'b1));
    issue_npc(32'h8000_0002);
    run_fetch("misalign", 32'h8000_0002, -1, 2);

    // reset while in WAIT
    r_dly = 20;
    issue_npc(32'h8000_0010);
    @(negedge clk);
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    @(negedge clk);
    check("wait rready", 32'(bus.rready), 32'd1);
    mem_en      = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    rst         = 1'b1;
    #1;
    check_reset_vals("midrst");
    sb.delete();
    @(negedge clk);
    rst        = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    bus.rresp  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray arvalid",    32'(bus.arvalid),    32'd1);
      check("stray araddr",     bus.araddr,          RESET_PC);
      check("stray inst_valid", 32'(bus.inst_valid), 32'd0);
    end
    bus.rvalid = 1'b0;
    r_dly      = 0;
    #1;
    mem_en = 1'b1;
    sb.push_back(mk(32'h0010_0093, RESET_PC, 1'b0));
    run_fetch("restart", RESET_PC, 1, 3);

    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("scoreboard empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
